array_mult_8bit: RTL and testbench

- Unsigned 8x8 -> 16-bit multiplier built as a classic AND-gate / full-adder array (no `*` operator).
- Structure: combinational array core, followed by one output register stage.
- Used as a standalone arithmetic datapath block in the ASIC lab flow.
- Operands are sampled every clock; the product is registered and presented one cycle later.

---
 rtl/array_mult_8bit_pkg.sv | 7 +
 rtl/array_mult_8bit_if.sv | 13 +
 rtl/array_mult_8bit_full_adder.sv | 13 +
 rtl/array_mult_8bit.sv | 77 +++++++
 tb/tb_array_mult_8bit.sv | 118 +++++++++++
 5 files changed

// File: rtl/array_mult_8bit_pkg.sv
// Shared width constants for the 8x8 array multiplier.
// Latency: n/a (constants only).
// Backpressure: n/a.
package array_mult_8bit_pkg;
   localparam int OPW   = 8;   // operand width
   localparam int PRODW = 16;  // product width
endpackage

// File: rtl/array_mult_8bit_if.sv
// Operand/product bundle for array_mult_8bit.
// Ports: A, B (8-bit unsigned operands), Z (16-bit registered product).
// Backpressure: none, a new operand pair is accepted every clock.
interface array_mult_8bit_if
   import array_mult_8bit_pkg::*;
   ();
   logic [OPW-1:0]   A;
   logic [OPW-1:0]   B;
   logic [PRODW-1:0] Z;

   modport master (output A, output B, input Z);
   modport slave  (input A, input B, output Z);
endinterface

// File: rtl/array_mult_8bit_full_adder.sv
// One-bit full adder cell of the multiplier array (half adder when cin=0).
// Ports: a, b, cin -> sum, cout. Purely combinational, zero latency.
// Backpressure: none.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/array_mult_8bit.sv
// Unsigned 8x8 -> 16 array multiplier: AND partial products, ripple adder grid, output register.
// Ports: clk, rst (sync, active-high), bus.A/bus.B operands, bus.Z product. Latency 1 cycle.
// Backpressure: none, one product per clock, no handshake.
module array_mult_8bit
   import array_mult_8bit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   array_mult_8bit_if.slave  bus
);
   logic [OPW-1:0]   pp [0:OPW-1];  // pp[i][j] = A[j] & B[i]
   logic [PRODW-1:0] prod_c;        // combinational product

   genvar i, j, k;

   generate
      for (i = 0; i < OPW; i++) begin : g_pp
         assign pp[i] = bus.A & {OPW{bus.B[i]}};
      end

      // Row i adds partial-product row i to the previous row's running sum
      // shifted down one bit; the bit dropped off the bottom is Z[i].
      // Row 0 has nothing above it, so its cells just pass pp[0] through.
      // Each cell is a scalar net so the carry ripple is bit-level, not a
      // self-referencing vector.
      for (i = 0; i < OPW; i++) begin : g_row
         for (j = 0; j < OPW; j++) begin : g_col
            logic x, y, cin, s, cout;

            assign x = pp[i][j];

            if (i == 0) begin : g_y_top
               assign y = 1'b0;
            end else if (j == OPW-1) begin : g_y_carry
               // MSB of the previous row's sum is its final carry-out
               assign y = g_row[i-1].g_col[OPW-1].cout;
            end else begin : g_y_sum
               assign y = g_row[i-1].g_col[j+1].s;
            end

            if (j == 0) begin : g_cin_zero
               assign cin = 1'b0;
            end else begin : g_cin_ripple
               assign cin = g_row[i].g_col[j-1].cout;
            end

            full_adder u_fa (
               .a    (x),
               .b    (y),
               .cin  (cin),
               .sum  (s),
               .cout (cout)
            );
         end

         // Low product bits come from the LSB of each row
         assign prod_c[i] = g_col[0].s;
      end

      // High product bits are the last row's sum above its LSB plus its carry-out
      for (k = 0; k < OPW; k++) begin : g_hi
         if (k == OPW-1) begin : g_hi_carry
            assign prod_c[OPW+k] = g_row[OPW-1].g_col[OPW-1].cout;
         end else begin : g_hi_sum
            assign prod_c[OPW+k] = g_row[OPW-1].g_col[k+1].s;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.Z <= '0;
      end else begin
         bus.Z <= prod_c;
      end
   end
endmodule

// File: tb/tb_array_mult_8bit.sv
// Bench for array_mult_8bit: directed literal cases, exhaustive sweep, random stream with resets.
// Ports: drives clk, rst and the operand interface; Z checked one edge after operands.
// Backpressure: none.
module tb_array_mult_8bit;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [15:0] exp_z;
   logic        model_vld;

   array_mult_8bit_if bus ();

   array_mult_8bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0d (0x%h) want=%0d (0x%h) at %0t", name, act, act, want, want, $time);
      end
   endtask

   // Reference model: whatever is sampled at an edge must appear on Z after it.
   initial model_vld = 1'b0;
   always @(posedge clk) begin
      model_vld <= 1'b1;
      exp_z     <= rst ? 16'h0000 : (16'(bus.A) * 16'(bus.B));
   end

   // Stream compare on every falling edge once the model holds a value.
   always @(negedge clk) begin
      if (model_vld) check("stream", bus.Z, exp_z);
   end

   // Apply operands, wait one edge, check DUT and model against a literal.
   task automatic apply(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] want, input string name);
      bus.A = a;
      bus.B = b;
      @(posedge clk);
      #1;
      check(name, bus.Z, want);
      check({"model_", name}, exp_z, want);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.A = 8'hFF;
      bus.B = 8'hFF;

      // Two reset edges with max operands present
      for (int n = 0; n < 2; n++) begin
         @(posedge clk);
         #1;
         check("reset_z", bus.Z, 16'h0000);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset", bus.Z, 16'd65025);

      apply(8'd0,   8'd0,   16'd0,     "zero_zero");
      apply(8'd127, 8'd127, 16'd16129, "127x127");
      apply(8'd150, 8'd50,  16'd7500,  "150x50");
      apply(8'd255, 8'd255, 16'hFE01,  "255x255");
      apply(8'd1,   8'd255, 16'd255,   "identity");
      apply(8'd128, 8'd2,   16'd256,   "shift");
      apply(8'd0,   8'd200, 16'd0,     "zero_a");
      apply(8'd64,  8'd4,   16'd256,   "pow2");

      // Back-to-back, then reset in the middle of the sequence
      apply(8'd10, 8'd10, 16'd100, "seq10");
      apply(8'd20, 8'd20, 16'd400, "seq20");
      apply(8'd30, 8'd30, 16'd900, "seq30");
      rst = 1'b1;
      apply(8'd40, 8'd40, 16'd0,   "mid_reset");
      rst = 1'b0;
      apply(8'd50, 8'd50, 16'd2500, "resume50");
      apply(8'd60, 8'd60, 16'd3600, "resume60");

      // Exhaustive sweep; the stream compare checks each product
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            bus.A = 8'(a);
            bus.B = 8'(b);
            @(posedge clk);
            #1;
         end
      end

      // Random operands with occasional reset pulses
      for (int n = 0; n < 2000; n++) begin
         bus.A = 8'($urandom_range(255, 0));
         bus.B = 8'($urandom_range(255, 0));
         rst   = ($urandom_range(15, 0) == 0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      apply(8'd3, 8'd7, 16'd21, "after_random");

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
